sprite_cmd_queue: RTL and testbench

Command queue that sits directly upstream of the sprite display components (Bowser and siblings). It accepts 32-bit command words from the Avalon-MM slave, buffers them in a FIFO, and releases them onto the shared `writedata` bus only during vertical blanking. This keeps sprite state from changing mid-scanline. Draining stops after each frame-commit (buffer-toggle) command, so exactly one frame of updates is applied per blanking interval.

---
 rtl/sprite_cmd_queue.sv | 133 +++++++++++++
 tb/tb_sprite_cmd_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_cmd_queue.sv
// Vblank-gated command FIFO feeding the sprite display blocks.
// Optional CMDQ_DROP_ON_FULL_EN: drop writes to a full FIFO instead of stalling.
module sprite_cmd_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned VBLANK_START = 480,
  parameter logic [31:0] IDLE_WORD    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  output logic                   avs_waitrequest,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  output logic [31:0]            cmd_out,
  output logic                   cmd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [9:0] VB = 10'(VBLANK_START);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    HOLD
  } state_e;

  state_e        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          vblank_q;
  logic [31:0]   cmd_q;
  logic          valid_q;
  logic          done_q;

  logic          in_vblank;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          pop_commit;
  logic [31:0]   head;
  logic          unused_hcount;

  assign unused_hcount = ^hcount;

  assign in_vblank  = (vcount >= VB);
  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign pop        = (state_q == DRAIN) && in_vblank && !empty;
  assign pop_commit = pop && (head[20:17] == 4'hF);
  // full is sampled before any pop, so a full FIFO refuses the push
  assign push       = avs_write && !full;
  assign level_d    = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= avs_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      vblank_q <= 1'b1;
      cmd_q    <= IDLE_WORD;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vblank_q <= in_vblank;
      cmd_q    <= pop ? head : IDLE_WORD;
      valid_q  <= pop;
      done_q   <= pop_commit;
      unique case (state_q)
        IDLE: begin
          if (in_vblank && !vblank_q) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!in_vblank)      state_q <= IDLE;
          else if (pop_commit) state_q <= HOLD;
        end
        HOLD: begin
          if (!in_vblank) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CMDQ_DROP_ON_FULL_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (avs_write && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign avs_waitrequest = 1'b0;
  assign overflow        = ovf_q;
`else
  assign avs_waitrequest = full;
  assign overflow        = 1'b0;
`endif

  assign cmd_out    = cmd_q;
  assign cmd_valid  = valid_q;
  assign frame_done = done_q;
  assign level      = level_q;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Bench for sprite_cmd_queue: queue-based reference model checked every
// cycle, plus directed literal checks for each scenario.
module tb_sprite_cmd_queue;

  localparam int DEPTH = 16;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic        avs_waitrequest;
  logic [9:0]  hcount = 10'd0;
  logic [9:0]  vcount = 10'd0;
  logic [31:0] cmd_out;
  logic        cmd_valid;
  logic [4:0]  level;
  logic        frame_done;
  logic        overflow;

  int total = 0;
  int bad = 0;

  sprite_cmd_queue dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_waitrequest (avs_waitrequest),
    .hcount          (hcount),
    .vcount          (vcount),
    .cmd_out         (cmd_out),
    .cmd_valid       (cmd_valid),
    .level           (level),
    .frame_done      (frame_done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) hcount <= hcount + 10'd1;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endfunction

  // Reference model: a word queue plus blanking/frame bookkeeping
  logic [31:0] mq[$];
  int          mmode = 0;
  bit          mvbq = 1'b1;
  logic [31:0] mout = IDLE;
  bit          mval = 1'b0;
  bit          mfd = 1'b0;
  bit          movf = 1'b0;

  always @(posedge clk) begin
    bit          inv;
    bit          wasfull;
    bit          p;
    logic [31:0] w;
    if (!reset_n) begin
      mq.delete();
      mmode = 0;
      mvbq  = 1'b1;
      mout  = IDLE;
      mval  = 1'b0;
      mfd   = 1'b0;
      movf  = 1'b0;
    end else begin
      inv     = (vcount >= 10'd480);
      wasfull = (mq.size() == DEPTH);
      p       = (mmode == 1) && inv && (mq.size() > 0);
      w       = IDLE;
      if (p) w = mq.pop_front();
      if (avs_write) begin
        if (!wasfull) mq.push_back(avs_writedata);
`ifdef CMDQ_DROP_ON_FULL_EN
        else movf = 1'b1;
`endif
      end
      mout = p ? w : IDLE;
      mval = p;
      mfd  = p && (w[20:17] == 4'hF);
      case (mmode)
        0: if (inv && !mvbq) mmode = 1;
        1: if (!inv) mmode = 0; else if (mfd) mmode = 2;
        default: if (!inv) mmode = 0;
      endcase
      mvbq = inv;
    end
    #1;
    chk("m_cmd_out", cmd_out, mout);
    chk("m_cmd_valid", 32'(cmd_valid), 32'(mval));
    chk("m_frame_done", 32'(frame_done), 32'(mfd));
    chk("m_level", 32'(level), 32'(mq.size()));
    chk("m_overflow", 32'(overflow), 32'(movf));
`ifdef CMDQ_DROP_ON_FULL_EN
    chk("m_waitreq", 32'(avs_waitrequest), 32'd0);
`else
    chk("m_waitreq", 32'(avs_waitrequest), 32'(mq.size() == DEPTH));
`endif
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] w);
    avs_write = 1'b1;
    avs_writedata = w;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic wr_wait(input logic [31:0] w, input int budget,
                         output int waited);
    avs_write = 1'b1;
    avs_writedata = w;
    waited = 0;
    while (avs_waitrequest && waited < budget) begin
      tick();
      waited++;
    end
    chk("wr_wait_bound", 32'(waited < budget), 32'd1);
    tick();
    avs_write = 1'b0;
  endtask

  task automatic do_reset();
    avs_write = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int waited;
    tick();
    tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_cmd_out", cmd_out, IDLE);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    reset_n = 1'b1;
    vcount = 10'd100;
    tick();

    // Basic issue and commit, then a write during HOLD stays queued
    wr(32'h2402_0000);
    wr(32'h241E_2000);
    chk("t1_level2", 32'(level), 32'd2);
    vcount = 10'd479;
    tick();
    vcount = 10'd480;
    tick();
    chk("t1_nopop_yet", 32'(cmd_valid), 32'd0);
    tick();
    chk("t1_word1", cmd_out, 32'h2402_0000);
    chk("t1_fd0", 32'(frame_done), 32'd0);
    tick();
    chk("t1_commit", cmd_out, 32'h241E_2000);
    chk("t1_fd1", 32'(frame_done), 32'd1);
    tick();
    chk("t1_level0", 32'(level), 32'd0);
    chk("t1_idle", cmd_out, IDLE);
    wr(32'h0C02_0003);
    tick();
    tick();
    chk("t1_hold_novalid", 32'(cmd_valid), 32'd0);
    chk("t1_hold_level", 32'(level), 32'd1);
    vcount = 10'd100;
    tick();

    // Two frames queued
    do_reset();
    tick();
    wr(32'h0C02_0001);
    wr(32'h241E_0001);
    wr(32'h0C02_0002);
    wr(32'h241E_0002);
    vcount = 10'd480;
    tick();
    tick();
    chk("t2_A", cmd_out, 32'h0C02_0001);
    tick();
    chk("t2_C1", cmd_out, 32'h241E_0001);
    chk("t2_C1_fd", 32'(frame_done), 32'd1);
    tick();
    chk("t2_level2", 32'(level), 32'd2);
    chk("t2_gap", 32'(cmd_valid), 32'd0);
    vcount = 10'd100;
    tick();
    tick();
    vcount = 10'd480;
    tick();
    tick();
    chk("t2_B", cmd_out, 32'h0C02_0002);
    tick();
    chk("t2_C2", cmd_out, 32'h241E_0002);
    chk("t2_C2_fd", 32'(frame_done), 32'd1);
    tick();
    chk("t2_level0", 32'(level), 32'd0);
    vcount = 10'd100;
    tick();

    // Drain cut off after 5 pops
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) wr(32'h0C02_0100 + 32'(i));
    chk("t3_level16", 32'(level), 32'd16);
`ifdef CMDQ_DROP_ON_FULL_EN
    for (int i = 0; i < 4; i++) wr(32'h0C02_01F0 + 32'(i));
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_level_drop", 32'(level), 32'd16);
    chk("t3_wreq0", 32'(avs_waitrequest), 32'd0);
`else
    chk("t3_wreq1", 32'(avs_waitrequest), 32'd1);
`endif
    vcount = 10'd480;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick();
      if (cmd_valid) n++;
    end
    vcount = 10'd100;
    chk("t3_five", 32'(n), 32'd5);
    chk("t3_last", cmd_out, 32'h0C02_0104);
    tick();
    chk("t3_level11", 32'(level), 32'd11);
    chk("t3_idle", cmd_out, IDLE);
    tick();
    chk("t3_novalid", 32'(cmd_valid), 32'd0);

    // Full FIFO
    for (int i = 0; i < 5; i++) wr(32'h0C02_0200 + 32'(i));
    chk("t4_level16", 32'(level), 32'd16);
`ifdef CMDQ_DROP_ON_FULL_EN
    wr(32'h0C02_02AA);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_level16b", 32'(level), 32'd16);
`else
    chk("t4_wreq", 32'(avs_waitrequest), 32'd1);
    vcount = 10'd480;
    wr_wait(32'h0C02_02AA, 20, waited);
    vcount = 10'd100;
    chk("t4_waited", 32'(waited), 32'd2);
    chk("t4_level15", 32'(level), 32'd15);
`endif
    tick();

    // Reset mid-drain
    do_reset();
    tick();
    for (int i = 0; i < 8; i++) wr(32'h0C02_0300 + 32'(i));
    vcount = 10'd480;
    tick();
    tick();
    tick();
    chk("t5_level6", 32'(level), 32'd6);
    chk("t5_popped", cmd_out, 32'h0C02_0301);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_cmd", cmd_out, IDLE);
    chk("t5_rst_level", 32'(level), 32'd0);
    chk("t5_rst_valid", 32'(cmd_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    wr(32'h0C02_0400);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_nodrain", 32'(cmd_valid), 32'd0);
    end
    chk("t5_level1", 32'(level), 32'd1);
    vcount = 10'd100;
    tick();

    // Push during DRAIN with level 1
    vcount = 10'd480;
    tick();
    avs_write = 1'b1;
    avs_writedata = 32'h0C02_0500;
    tick();
    avs_write = 1'b0;
    chk("t6_level1", 32'(level), 32'd1);
    chk("t6_first", cmd_out, 32'h0C02_0400);
    tick();
    chk("t6_second", cmd_out, 32'h0C02_0500);
    chk("t6_level0", 32'(level), 32'd0);
    vcount = 10'd100;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
